uart_io_ctrl: RTL and testbench
===============================

// Module: uart_io_ctrl
// PURPOSE
//  Core-side end of the byte interface to uart_tx/uart_rx. Buffers outgoing bytes
//  from the core in a TX FIFO and issues them to uart_tx via tx_start/tx_busy; captures
//  bytes from uart_rx (rx_ready/rdata/ferr) into an RX FIFO read by the core.
//  Sits between the core's I/O unit and the UART serializer/deserializer.
// PARAMETERS
//  TX_DEPTH  16  TX FIFO entries, power of 2, >=2
//  RX_DEPTH  16  RX FIFO entries, power of 2, >=2
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  tx_wdata     in   8   byte from core to send
//  tx_wvalid    in   1   core offers tx_wdata
//  tx_wready    out  1   TX FIFO not full; write accepted when tx_wvalid & tx_wready
//  tx_count     out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
//  rx_rdata     out  8   head of RX FIFO (first-word fall-through)
//  rx_rvalid    out  1   RX FIFO not empty
//  rx_rready    in   1   core pops head when rx_rvalid & rx_rready
//  rx_count     out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
//  err_clr      in   1   clears rx_overrun and rx_ferr
//  rx_overrun   out  1   sticky: a received byte was dropped, RX FIFO full
//  rx_ferr      out  1   sticky: a byte arrived with ferr=1 (byte dropped)
//  txdata       out  8   byte to uart_tx, stable from tx_start until tx_busy falls
//  tx_start     out  1   one-cycle start pulse to uart_tx
//  tx_busy      in   1   uart_tx busy (rises the cycle after tx_start)
//  rdata        in   8   byte from uart_rx
//  rx_ready     in   1   uart_rx byte-valid strobe
//  ferr         in   1   uart_rx framing error, sampled with rx_ready
// BEHAVIOUR
//  Reset (async, rst=1): FIFOs empty, counts 0, tx_wready=1, rx_rvalid=0, rx_rdata=0,
//   txdata=0, tx_start=0, rx_overrun=0, rx_ferr=0, TX FSM in IDLE, rx_ready edge reg=0.
//  TX FIFO: write when tx_wvalid & tx_wready; writes while full are not accepted.
//  TX FSM (all outputs registered):
//   IDLE:      if TX FIFO non-empty & tx_busy=0: pop head into txdata, tx_start<=1 -> START
//   START:     tx_start<=0 -> WAIT_BUSY
//   WAIT_BUSY: wait tx_busy=1 -> WAIT_DONE
//   WAIT_DONE: wait tx_busy=0 -> IDLE
//  Latency: write accepted at edge k into empty FIFO -> tx_start high for exactly the
//   cycle after edge k+1. Back-to-back bytes: next tx_start no earlier than 2 cycles
//   after tx_busy falls (WAIT_DONE->IDLE, IDLE->START). Pop and write in same cycle OK.
//  After reset with uart_tx still busy, IDLE waits for tx_busy=0 before any tx_start.
//  RX capture: one byte per rising edge of rx_ready (rx_ready & ~rx_ready_q);
//   rx_ready held high several cycles = one byte.
//   ferr=1 at capture: byte dropped, rx_ferr<=1.
//   else RX FIFO full and no pop this cycle: byte dropped, rx_overrun<=1.
//   else push rdata (push+pop when full permitted; count unchanged).
//  rx_rdata/rx_rvalid reflect FIFO head combinationally from registered state; pushed
//   byte visible on rx_rvalid the cycle after capture edge.
//  err_clr clears both sticky flags; a new error in the same cycle wins (flag stays 1).
//  Pointers wrap modulo depth; counts range 0..DEPTH inclusive.
// TESTING
//  1 Write 0x41 into empty TX -> tx_start single pulse 2 edges later, txdata=0x41 held
//    until tx_busy falls; tx_count 1->0 on pop.
//  2 Write 0x01..0x10 back-to-back (TX_DEPTH=16) while tx_busy stuck high -> tx_wready=0
//    after 16th write, 17th not accepted; release busy -> bytes sent in order 0x01..0x10.
//  3 Pulse rx_ready with rdata=0xAA, 0x55, ferr=0 -> rx_rvalid=1, rx_rdata 0xAA then 0x55
//    on pops, rx_count 2->1->0.
//  4 Fill RX to 16, one more rx_ready with rx_rready=0 -> byte dropped, rx_overrun=1;
//    repeat with rx_rready=1 same cycle -> accepted, no overrun; err_clr -> flag 0.
//  5 rx_ready with ferr=1, rdata=0x7E -> rx_count unchanged, rx_ferr=1; rx_ready held
//    3 cycles -> exactly one byte captured.
//  6 Assert rst mid-WAIT_DONE with 4 bytes queued -> all outputs to reset values at once;
//    no tx_start until tx_busy=0; FIFOs empty after release.

Source files
------------

// File: rtl/uart_io_ctrl.sv
// Generic single-clock FIFO with first-word fall-through head and occupancy count.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: caller must only push when not full (or full with a pop in the same cycle).
module uart_io_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    // Head reads as zero when empty so the core never sees stale bytes.
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// Core-side byte buffering for uart_tx/uart_rx: TX FIFO feeding a start/busy handshake, RX FIFO fed by rx_ready edges.
// Latency: TX write at edge k -> tx_start high after edge k+1; RX capture edge -> rx_rvalid the next cycle.
// Backpressure: tx_wready drops when the TX FIFO is full; RX bytes arriving into a full FIFO are dropped and flagged.
module uart_io_ctrl #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   tx_wdata,
    input  logic                         tx_wvalid,
    output logic                         tx_wready,
    output logic [$clog2(TX_DEPTH):0]    tx_count,
    output logic [7:0]                   rx_rdata,
    output logic                         rx_rvalid,
    input  logic                         rx_rready,
    output logic [$clog2(RX_DEPTH):0]    rx_count,
    input  logic                         err_clr,
    output logic                         rx_overrun,
    output logic                         rx_ferr,
    output logic [7:0]                   txdata,
    output logic                         tx_start,
    input  logic                         tx_busy,
    input  logic [7:0]                   rdata,
    input  logic                         rx_ready,
    input  logic                         ferr
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic       tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_empty, rx_full;

    logic [1:0] state_q, state_d;
    logic [7:0] txdata_q, txdata_d;
    logic       tx_start_q, tx_start_d;
    logic       rx_ready_q, rx_ready_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rx_cap, new_ferr, new_ovr;

    uart_io_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .push_dat (tx_wdata),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .empty    (tx_empty),
        .full     (tx_full),
        .count    (tx_count)
    );

    uart_io_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (rdata),
        .pop      (rx_pop),
        .head_dat (rx_rdata),
        .empty    (rx_empty),
        .full     (rx_full),
        .count    (rx_count)
    );

    assign tx_wready = ~tx_full;
    assign tx_push   = tx_wvalid & ~tx_full;

    // Launch only from IDLE with the serializer quiet, so a busy uart_tx after reset is respected.
    always_comb begin
        state_d    = state_q;
        txdata_d   = txdata_q;
        tx_start_d = 1'b0;
        tx_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    tx_pop     = 1'b1;
                    txdata_d   = tx_head;
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START:     state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    assign rx_rvalid = ~rx_empty;
    assign rx_pop    = rx_rvalid & rx_rready;
    assign rx_cap    = rx_ready & ~rx_ready_q;

    always_comb begin
        rx_ready_d = rx_ready;
        rx_push    = 1'b0;
        new_ferr   = 1'b0;
        new_ovr    = 1'b0;
        if (rx_cap) begin
            if (ferr) begin
                new_ferr = 1'b1;
            end else if (rx_full && !rx_pop) begin
                new_ovr = 1'b1;
            end else begin
                rx_push = 1'b1;
            end
        end
        // A fresh error in the clearing cycle keeps the flag set.
        rx_ferr_d    = (rx_ferr_q    & ~err_clr) | new_ferr;
        rx_overrun_d = (rx_overrun_q & ~err_clr) | new_ovr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            txdata_q     <= '0;
            tx_start_q   <= 1'b0;
            rx_ready_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            txdata_q     <= txdata_d;
            tx_start_q   <= tx_start_d;
            rx_ready_q   <= rx_ready_d;
            rx_overrun_q <= rx_overrun_d;
            rx_ferr_q    <= rx_ferr_d;
        end
    end

    assign txdata     = txdata_q;
    assign tx_start   = tx_start_q;
    assign rx_overrun = rx_overrun_q;
    assign rx_ferr    = rx_ferr_q;
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl with a small uart_tx busy model and TX/RX scoreboards.
// Latency: checks tx_start timing and RX visibility cycle-exactly at chosen points.
// Backpressure: exercises full TX FIFO, full RX FIFO with and without a same-cycle pop.
module tb_uart_io_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_wdata = '0;
    logic       tx_wvalid = 1'b0;
    logic       tx_wready;
    logic [4:0] tx_count;
    logic [7:0] rx_rdata;
    logic       rx_rvalid;
    logic       rx_rready = 1'b0;
    logic [4:0] rx_count;
    logic       err_clr = 1'b0;
    logic       rx_overrun, rx_ferr;
    logic [7:0] txdata;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rdata = '0;
    logic       rx_ready = 1'b0;
    logic       ferr = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] last_tx = '0;
    bit         have_last = 1'b0;
    logic       hold_busy = 1'b0;
    int         busy_cnt = 0;

    always #5 clk = ~clk;

    uart_io_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tx_wdata   (tx_wdata),
        .tx_wvalid  (tx_wvalid),
        .tx_wready  (tx_wready),
        .tx_count   (tx_count),
        .rx_rdata   (rx_rdata),
        .rx_rvalid  (rx_rvalid),
        .rx_rready  (rx_rready),
        .rx_count   (rx_count),
        .err_clr    (err_clr),
        .rx_overrun (rx_overrun),
        .rx_ferr    (rx_ferr),
        .txdata     (txdata),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .rdata      (rdata),
        .rx_ready   (rx_ready),
        .ferr       (ferr)
    );

    // uart_tx stand-in: busy rises the edge after tx_start and stays up for 5 cycles.
    assign tx_busy = hold_busy | (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_start && !rst) busy_cnt <= 5;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            have_last = 1'b0;
        end else begin
            if (tx_start) begin
                start_cnt++;
                if (txq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected_start: got txdata 0x%0h, expected no start", txdata);
                end else begin
                    last_tx = txq.pop_front();
                    chk("tx_byte", {24'd0, txdata}, {24'd0, last_tx});
                    have_last = 1'b1;
                end
            end else if (tx_busy && have_last) begin
                chk("tx_hold", {24'd0, txdata}, {24'd0, last_tx});
            end
            if (rx_rvalid && rx_rready) begin
                if (rxq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rx_unexpected_pop: got 0x%0h, expected empty FIFO", rx_rdata);
                end else begin
                    chk("rx_byte", {24'd0, rx_rdata}, {24'd0, rxq.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] d, input bit acc);
        chk("tx_wready", {31'd0, tx_wready}, {31'd0, acc});
        tx_wdata  = d;
        tx_wvalid = 1'b1;
        if (acc) txq.push_back(d);
        tick();
        tx_wvalid = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d, input bit fe, input int hold);
        rdata    = d;
        ferr     = fe;
        rx_ready = 1'b1;
        repeat (hold) tick();
        rx_ready = 1'b0;
        ferr     = 1'b0;
        tick();
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        while ((tx_count != 0 || tx_busy || tx_start || txq.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_drain_timeout: got tx_count %0d, expected 0 within 2000 cycles", tx_count);
        end
        repeat (2) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_count"},   {27'd0, tx_count},   32'd0);
        chk({tag, "_tx_wready"},  {31'd0, tx_wready},  32'd1);
        chk({tag, "_tx_start"},   {31'd0, tx_start},   32'd0);
        chk({tag, "_txdata"},     {24'd0, txdata},     32'd0);
        chk({tag, "_rx_rvalid"},  {31'd0, rx_rvalid},  32'd0);
        chk({tag, "_rx_rdata"},   {24'd0, rx_rdata},   32'd0);
        chk({tag, "_rx_count"},   {27'd0, rx_count},   32'd0);
        chk({tag, "_rx_overrun"}, {31'd0, rx_overrun}, 32'd0);
        chk({tag, "_rx_ferr"},    {31'd0, rx_ferr},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Single byte: start pulse exactly one cycle, two edges after the write.
        tx_write(8'h41, 1'b1);
        chk("t1_count_after_write", {27'd0, tx_count}, 32'd1);
        chk("t1_start_early",       {31'd0, tx_start}, 32'd0);
        tick();
        chk("t1_start",             {31'd0, tx_start}, 32'd1);
        chk("t1_txdata",            {24'd0, txdata},   32'h41);
        chk("t1_count_after_pop",   {27'd0, tx_count}, 32'd0);
        tick();
        chk("t1_start_pulse_end",   {31'd0, tx_start}, 32'd0);
        wait_tx_idle();

        // Fill TX while uart_tx is stuck busy, then drain in order.
        hold_busy = 1'b1;
        for (int i = 1; i <= 16; i++) tx_write(8'(i), 1'b1);
        chk("t2_count_full", {27'd0, tx_count}, 32'd16);
        tx_write(8'h11, 1'b0);
        chk("t2_count_after_17th", {27'd0, tx_count}, 32'd16);
        chk("t2_no_start_busy", start_cnt, 32'd1);
        hold_busy = 1'b0;
        wait_tx_idle();
        chk("t2_all_sent", start_cnt, 32'd17);

        // Two RX bytes, popped in order.
        rxq.push_back(8'hAA);
        rdata = 8'hAA;
        rx_ready = 1'b1;
        tick();
        chk("t3_rvalid", {31'd0, rx_rvalid}, 32'd1);
        chk("t3_head",   {24'd0, rx_rdata},  32'hAA);
        rx_ready = 1'b0;
        tick();
        rxq.push_back(8'h55);
        rx_pulse(8'h55, 1'b0, 1);
        chk("t3_count2", {27'd0, rx_count}, 32'd2);
        rx_rready = 1'b1; tick(); rx_rready = 1'b0;
        chk("t3_count1", {27'd0, rx_count}, 32'd1);
        chk("t3_head2",  {24'd0, rx_rdata}, 32'h55);
        rx_rready = 1'b1; tick(); rx_rready = 1'b0;
        chk("t3_count0",  {27'd0, rx_count},  32'd0);
        chk("t3_rvalid0", {31'd0, rx_rvalid}, 32'd0);

        // RX full: drop + overrun; clear; push+pop when full; error beats clear.
        for (int i = 0; i < 16; i++) begin
            rxq.push_back(8'h80 + 8'(i));
            rx_pulse(8'h80 + 8'(i), 1'b0, 1);
        end
        chk("t4_count_full", {27'd0, rx_count}, 32'd16);
        rx_pulse(8'hEE, 1'b0, 1);
        chk("t4_overrun",       {31'd0, rx_overrun}, 32'd1);
        chk("t4_count_dropped", {27'd0, rx_count},   32'd16);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t4_overrun_clr", {31'd0, rx_overrun}, 32'd0);
        rxq.push_back(8'hDD);
        rdata = 8'hDD; rx_ready = 1'b1; rx_rready = 1'b1;
        tick();
        rx_ready = 1'b0; rx_rready = 1'b0;
        chk("t4_pushpop_count",   {27'd0, rx_count},   32'd16);
        chk("t4_pushpop_overrun", {31'd0, rx_overrun}, 32'd0);
        chk("t4_pushpop_head",    {24'd0, rx_rdata},   32'h81);
        tick();
        rdata = 8'hEF; rx_ready = 1'b1; err_clr = 1'b1;
        tick();
        rx_ready = 1'b0; err_clr = 1'b0;
        chk("t4_err_wins", {31'd0, rx_overrun}, 32'd1);
        tick();
        rx_rready = 1'b1;
        repeat (16) tick();
        rx_rready = 1'b0;
        chk("t4_drained", {27'd0, rx_count}, 32'd0);
        chk("t4_rxq_empty", rxq.size(), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Framing error drops the byte; a held rx_ready captures one byte only.
        rx_pulse(8'h7E, 1'b1, 1);
        chk("t5_count",  {27'd0, rx_count},  32'd0);
        chk("t5_ferr",   {31'd0, rx_ferr},   32'd1);
        chk("t5_rvalid", {31'd0, rx_rvalid}, 32'd0);
        rxq.push_back(8'h33);
        rx_pulse(8'h33, 1'b0, 3);
        chk("t5_held_one", {27'd0, rx_count}, 32'd1);
        chk("t5_head",     {24'd0, rx_rdata}, 32'h33);
        rx_rready = 1'b1; tick(); rx_rready = 1'b0;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t5_ferr_clr", {31'd0, rx_ferr}, 32'd0);

        // Reset mid-WAIT_DONE with 4 TX bytes queued and RX state dirty.
        rxq.push_back(8'h11);
        rx_pulse(8'h11, 1'b0, 1);
        rx_pulse(8'h22, 1'b1, 1);
        for (int i = 0; i < 5; i++) tx_write(8'hA0 + 8'(i), 1'b1);
        hold_busy = 1'b1;
        chk("t6_queued", {27'd0, tx_count}, 32'd4);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        txq.delete();
        rxq.delete();
        repeat (2) tick();
        rst = 1'b0;
        s = start_cnt;
        tx_write(8'h5A, 1'b1);
        repeat (10) tick();
        chk("t6_no_start_while_busy", start_cnt, s);
        chk("t6_count_waiting", {27'd0, tx_count}, 32'd1);
        hold_busy = 1'b0;
        wait_tx_idle();
        chk("t6_start_after_busy", start_cnt, s + 1);
        chk("t6_rx_empty", {27'd0, rx_count}, 32'd0);

        chk("final_txq_empty", txq.size(), 32'd0);
        chk("final_rxq_empty", rxq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
